// File: rtl/ram_arbiter_if.sv
// Master-side handshake bundle for ram_arbiter: two independent request
// ports (0 = CPU, 1 = DMA/video), each with request, direction, address,
// write data, and a one-cycle ack with read data.
//   slave  : arbiter view (requests in, ack/rdata out)
//   master : requester view (requests out, ack/rdata in)
interface ram_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-ported RAM
// with a bidirectional data bus. Serialises requests from two masters,
// runs each access for WAIT+1 cycles and acknowledges one cycle later.
// Ports:
//   clk      - system clock (rising edge)
//   r        - synchronous active-low reset
//   bus      - request/ack handshake for both masters (slave modport)
//   grant    - one-hot owner while a transaction is in flight
//   busy     - arbiter not idle
//   mem_addr - RAM address
//   mem_we   - RAM write enable, high only in the last access cycle
//   mem_oe   - RAM output enable, high in every read access cycle
//   mem_data - RAM data bus; driven by the arbiter only during write access
module ram_arbiter #(
  parameter int AW   = 24,
  parameter int DW   = 16,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          r,
  ram_arbiter_if.slave  bus,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_oe,
  inout  wire  [DW-1:0] mem_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  logic [1:0]         state;
  logic               last;     // port served most recently
  logic [3:0]         cnt;
  logic               wr_q;
  logic [DW-1:0]      wdata_q;
  logic               drv;      // arbiter owns mem_data this cycle
  logic [1:0]         ack;
  logic [1:0][DW-1:0] rdata;

  // Winner selection: on a tie the port not served last wins.
  logic          win;
  logic          win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    win       = (bus.req0 & bus.req1) ? ~last : bus.req1;
    win_wr    = win ? bus.wr1    : bus.wr0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state    <= IDLE;
      last     <= 1'b1;
      cnt      <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      drv      <= 1'b0;
      ack      <= '0;
      rdata    <= '0;
      grant    <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_oe   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            state    <= ACCESS;
            last     <= win;
            cnt      <= WAIT_C;
            wr_q     <= win_wr;
            wdata_q  <= win_wdata;
            mem_addr <= win_addr;
            grant    <= win ? 2'b10 : 2'b01;
            drv      <= win_wr;
            mem_oe   <= ~win_wr;
            // With no wait states the first access cycle is also the last.
            mem_we   <= win_wr & (WAIT_C == 4'd0);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            // Raise we one cycle ahead so it is seen only in the final cycle.
            mem_we <= wr_q & (cnt == 4'd1);
          end else begin
            if (!wr_q) rdata[last] <= mem_data;
            ack    <= grant;
            state  <= RESP;
            drv    <= 1'b0;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        RESP: begin
          ack   <= '0;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign mem_data   = drv ? wdata_q : {DW{1'bz}};
  assign bus.ack0   = ack[0];
  assign bus.ack1   = ack[1];
  assign bus.rdata0 = rdata[0];
  assign bus.rdata1 = rdata[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (WAIT=0 and WAIT=3), each
// with a small behavioural RAM on its bidirectional bus. Inputs change and
// outputs are checked just after the falling edge.
module tb_ram_arbiter;

  logic clk;
  logic r;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---- DUT with WAIT=0 ----
  ram_arbiter_if #(.AW(24), .DW(16)) b0 ();
  logic [1:0]  grant0;
  logic        busy0, we0, oe0;
  logic [23:0] ma0;
  wire  [15:0] md0;

  ram_arbiter #(.AW(24), .DW(16), .WAIT(0)) dut0 (
    .clk(clk), .r(r), .bus(b0), .grant(grant0), .busy(busy0),
    .mem_addr(ma0), .mem_we(we0), .mem_oe(oe0), .mem_data(md0)
  );

  // ---- DUT with WAIT=3 ----
  ram_arbiter_if #(.AW(24), .DW(16)) b3 ();
  logic [1:0]  grant3;
  logic        busy3, we3, oe3;
  logic [23:0] ma3;
  wire  [15:0] md3;

  ram_arbiter #(.AW(24), .DW(16), .WAIT(3)) dut3 (
    .clk(clk), .r(r), .bus(b3), .grant(grant3), .busy(busy3),
    .mem_addr(ma3), .mem_we(we3), .mem_oe(oe3), .mem_data(md3)
  );

  // ---- RAM models (64 words each), with a bench-side preload port ----
  logic [15:0] ram0 [0:63];
  logic [15:0] ram3 [0:63];
  logic        ld;
  logic [5:0]  ld_a;
  logic [15:0] ld_d;

  always @(posedge clk) begin
    if (we0)     ram0[ma0[5:0]] <= md0;
    else if (ld) ram0[ld_a]     <= ld_d;
    if (we3)     ram3[ma3[5:0]] <= md3;
    else if (ld) ram3[ld_a]     <= ld_d;
  end

  assign md0 = oe0 ? ram0[ma0[5:0]] : 16'hzzzz;
  assign md3 = oe3 ? ram3[ma3[5:0]] : 16'hzzzz;

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    ld = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    r = 1'b0; ld = 1'b0; ld_a = '0; ld_d = '0;
    b0.req0 = 0; b0.req1 = 0; b0.wr0 = 0; b0.wr1 = 0;
    b0.addr0 = '0; b0.addr1 = '0; b0.wdata0 = '0; b0.wdata1 = '0;
    b3.req0 = 0; b3.req1 = 0; b3.wr0 = 0; b3.wr1 = 0;
    b3.addr0 = '0; b3.addr1 = '0; b3.wdata0 = '0; b3.wdata1 = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_grant", grant0, 2'b00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ack", {b0.ack1, b0.ack0}, 2'b00);
    chk("rst_rdata0", b0.rdata0, 16'h0000);
    chk("rst_we_oe", {we0, oe0}, 2'b00);
    chk("rst_addr", ma0, 24'h0);
    r = 1'b1;

    // ---- single write, port 0, WAIT=0 ----
    b0.req0 = 1; b0.wr0 = 1; b0.addr0 = 24'h000010; b0.wdata0 = 16'hBEEF;
    @(negedge clk);  // ACCESS
    chk("wr_grant", grant0, 2'b01);
    chk("wr_we", we0, 1'b1);
    chk("wr_oe", oe0, 1'b0);
    chk("wr_addr", ma0, 24'h000010);
    chk("wr_data", md0, 16'hBEEF);
    chk("wr_ack_early", b0.ack0, 1'b0);
    b0.addr0 = 24'h3F; b0.wdata0 = 16'h0BAD;  // post-grant changes must not matter
    @(negedge clk);  // RESP
    chk("wr_ack", b0.ack0, 1'b1);
    chk("wr_we_resp", we0, 1'b0);
    chk("wr_grant_resp", grant0, 2'b01);
    b0.req0 = 0;
    @(negedge clk);  // IDLE
    chk("wr_ack_gone", b0.ack0, 1'b0);
    chk("wr_idle", {busy0, grant0}, 3'b000);
    chk("wr_ram", ram0[6'h10], 16'hBEEF);

    // ---- read-back, port 1 (wdata1 set so any stray drive would corrupt) ----
    b0.req1 = 1; b0.wr1 = 0; b0.addr1 = 24'h000010; b0.wdata1 = 16'h1234;
    @(negedge clk);
    chk("rd_grant", grant0, 2'b10);
    chk("rd_oe_we", {oe0, we0}, 2'b10);
    chk("rd_bus", md0, 16'hBEEF);
    @(negedge clk);
    chk("rd_ack", {b0.ack1, b0.ack0}, 2'b10);
    chk("rd_data", b0.rdata1, 16'hBEEF);
    chk("rd_oe_resp", oe0, 1'b0);
    b0.req1 = 0;
    @(negedge clk);
    chk("rd_ack_gone", b0.ack1, 1'b0);
    chk("rd_hold", b0.rdata1, 16'hBEEF);

    // ---- tie and fairness from reset ----
    preload(6'h01, 16'h1111);
    preload(6'h02, 16'h2222);
    r = 1'b0;
    b0.req0 = 1; b0.wr0 = 0; b0.addr0 = 24'h1;
    b0.req1 = 1; b0.wr1 = 0; b0.addr1 = 24'h2;
    @(negedge clk);
    r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_grant", grant0, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk("fair_ack", {b0.ack1, b0.ack0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k % 2 == 0) chk("fair_rd0", b0.rdata0, 16'h1111);
      else            chk("fair_rd1", b0.rdata1, 16'h2222);
      if (k == 3) begin b0.req0 = 0; b0.req1 = 0; end
      @(negedge clk);
      chk("fair_idle", {busy0, b0.ack1, b0.ack0}, 3'b000);
    end

    // ---- back-to-back writes on port 0 ----
    b0.req0 = 1; b0.wr0 = 1; b0.addr0 = 24'h20; b0.wdata0 = 16'hA000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_we", {we0, ma0[5:0]}, {1'b1, 6'(6'h20 + k)});
      @(negedge clk);
      chk("b2b_ack", b0.ack0, 1'b1);
      if (k == 3) b0.req0 = 0;
      else begin
        b0.addr0 = 24'(24'h20 + k + 1);
        b0.wdata0 = 16'(16'hA000 + k + 1);
      end
      @(negedge clk);
      chk("b2b_idle", {busy0, b0.ack0}, 2'b00);
    end
    for (int k = 0; k < 4; k++)
      chk("b2b_ram", ram0[6'(6'h20 + k)], 16'(16'hA000 + k));

    // ---- wait states: WAIT=3 write on port 0 ----
    b3.req0 = 1; b3.wr0 = 1; b3.addr0 = 24'h5; b3.wdata0 = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ws_access", {busy3, grant3, oe3}, 4'b1010);
      chk("ws_we", we3, (i == 3));
      chk("ws_data", md3, 16'h5A5A);
      chk("ws_noack", b3.ack0, 1'b0);
    end
    @(negedge clk);
    chk("ws_ack", b3.ack0, 1'b1);
    chk("ws_we_resp", we3, 1'b0);
    b3.req0 = 0;
    @(negedge clk);
    chk("ws_ram", ram3[6'h05], 16'h5A5A);

    // ---- reset in the middle of a WAIT=3 read ----
    preload(6'h07, 16'h7777);
    b3.req0 = 1; b3.wr0 = 0; b3.addr0 = 24'h7;
    @(negedge clk);  // ACCESS 1
    chk("mr_oe1", oe3, 1'b1);
    @(negedge clk);  // ACCESS 2
    r = 1'b0;
    @(negedge clk);
    chk("mr_state", {busy3, grant3, b3.ack0}, 4'b0000);
    chk("mr_mem", {we3, oe3, ma3}, 26'h0);
    chk("mr_rdata", b3.rdata0, 16'h0000);
    b3.req0 = 0; r = 1'b1;
    @(negedge clk);
    chk("mr_noack", b3.ack0, 1'b0);
    b3.req0 = 1;
    repeat (4) @(negedge clk);
    chk("mr2_access", {grant3, oe3}, 3'b011);
    @(negedge clk);
    chk("mr2_ack", b3.ack0, 1'b1);
    chk("mr2_data", b3.rdata0, 16'h7777);
    b3.req0 = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
